// File: rtl/sar_operand_search.sv
// rtl/sar_operand_search.sv - successive-approximation signed operand search against an external A<B comparator
//
// Purpose:
//   Binary-searches a WIDTH-bit two's-complement probe (operand B) until it equals a
//   hidden target (operand A) using only the comparator's less-than flag. The search
//   runs in offset binary so that setting bits MSB-first walks the signed range
//   monotonically; each trial is converted back to two's complement by flipping the MSB.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a search (sampled only in IDLE)
//   abort      synchronous cancel back to IDLE, no done pulse
//   probe      signed operand B presented to the comparator (registered)
//   probe_vld  probe is stable and a compare is requested
//   cmp_vld    comparator result valid for the current probe
//   cmp_lt     1 = target < probe (signed)
//   cmp_eq     1 = target == probe (only with SAR_EQ_EXIT_EN)
//   busy       search in progress
//   done       one-cycle pulse, result valid
//   result     signed search result, held until the next search completes
//
// Configuration:
//   SAR_EQ_EXIT_EN  adds cmp_eq; an equal compare ends the search early.
module sar_operand_search #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] probe,
  output logic             probe_vld,
  input  logic             cmp_vld,
  input  logic             cmp_lt,
`ifdef SAR_EQ_EXIT_EN
  input  logic             cmp_eq,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = ONE << (WIDTH - 1);
  localparam logic [IW-1:0]    TOP_IDX  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0] bit_i;
  logic [WIDTH-1:0] acc_upd;
  logic [WIDTH-1:0] next_probe;

  // acc only ever holds bits above idx, so OR-ing in the trial bit is exact.
  // target >= probe keeps the trial bit; target < probe drops it.
  always_comb begin
    bit_i      = ONE << idx;
    acc_upd    = cmp_lt ? acc : (acc | bit_i);
    next_probe = (acc_upd | (bit_i >> 1)) ^ MSB_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= TOP_IDX;
      probe     <= '0;
      probe_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            acc       <= '0;
            idx       <= TOP_IDX;
            // First trial is the offset-binary MSB alone, i.e. signed zero.
            probe     <= '0;
            probe_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= S_PROBE;
          end
        end

        S_PROBE: begin
          if (abort) begin
            probe_vld <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (cmp_vld) begin
`ifdef SAR_EQ_EXIT_EN
            // Equality wins over a (contradictory) less-than flag.
            if (cmp_eq) begin
              result    <= probe;
              done      <= 1'b1;
              probe_vld <= 1'b0;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else
`endif
            begin
              acc <= acc_upd;
              if (idx == '0) begin
                result    <= acc_upd ^ MSB_MASK;
                done      <= 1'b1;
                probe_vld <= 1'b0;
                busy      <= 1'b0;
                state     <= S_DONE;
              end else begin
                idx   <= idx - 1'b1;
                probe <= next_probe;
              end
            end
          end
        end

        S_DONE: begin
          // One cycle with done high; start here is ignored.
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          probe_vld <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_operand_search.sv
// tb/tb_sar_operand_search.sv - self-checking bench for sar_operand_search
module tb_sar_operand_search;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] probe;
  logic         probe_vld;
  logic         cmp_vld;
  logic         cmp_lt;
`ifdef SAR_EQ_EXIT_EN
  logic         cmp_eq;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int passed = 0;
  int total  = 0;

  // Comparator model state
  logic [W-1:0] target_v = '0;
  int           delay    = 0;
  int           wait_cnt = 0;
  logic         noise_vld = 1'b0;
  logic         noise_lt  = 1'b0;

  int obs_probes[$];
  int exp_probes[$];
  int exp_result;

  always #5 clk = ~clk;

  sar_operand_search #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .probe     (probe),
    .probe_vld (probe_vld),
    .cmp_vld   (cmp_vld),
    .cmp_lt    (cmp_lt),
`ifdef SAR_EQ_EXIT_EN
    .cmp_eq    (cmp_eq),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // External comparator: answers `delay` cycles after a probe appears; random junk while idle.
  assign cmp_vld = probe_vld ? (wait_cnt >= delay) : noise_vld;
  assign cmp_lt  = probe_vld ? ($signed(target_v) < $signed(probe)) : noise_lt;
`ifdef SAR_EQ_EXIT_EN
  assign cmp_eq  = probe_vld && (probe == target_v);
`endif

  always @(posedge clk) begin
    noise_vld <= 1'($urandom);
    noise_lt  <= 1'($urandom);
    if (!probe_vld || cmp_vld) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  // Reference: interval-halving search over the signed range.
  function automatic void build_model(input int tgt);
    int lo, hi, p;
    bit hit;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    hit = 1'b0;
    p = 0;
    exp_probes.delete();
    for (int k = 0; k < W; k++) begin
      p = lo + (hi - lo + 1) / 2;
      exp_probes.push_back(p);
`ifdef SAR_EQ_EXIT_EN
      if (p == tgt) begin
        hit = 1'b1;
        break;
      end
`endif
      if (tgt < p) hi = p - 1;
      else         lo = p;
    end
    exp_result = hit ? p : lo;
  endfunction

  // Runs one search; returns observations, no comparisons here.
  task automatic do_search(input int tgt, input int dly, input bit poke,
                           output int done_cyc, output int res,
                           output bit stable_ok, output bit pulse_ok);
    logic [W-1:0] last_probe;
    bit prev_wait;
    logic [31:0] t32;
    t32 = tgt;
    target_v = t32[W-1:0];
    delay = dly;
    obs_probes.delete();
    stable_ok = 1'b1;
    pulse_ok = 1'b1;
    done_cyc = -1;
    res = 0;
    prev_wait = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last_probe = probe;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        res = int'($signed(result));
        if (busy !== 1'b0) pulse_ok = 1'b0;
        break;
      end
      if (probe_vld && prev_wait && probe !== last_probe) stable_ok = 1'b0;
      if (probe_vld && cmp_vld) begin
        obs_probes.push_back(int'($signed(probe)));
        prev_wait = 1'b0;
      end else begin
        prev_wait = probe_vld;
      end
      last_probe = probe;
      start = (poke && cyc < 20 && (cyc % 5) == 2);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0 || int'($signed(result)) != res) pulse_ok = 1'b0;
  endtask

  function automatic bit probes_match();
    if (obs_probes.size() != exp_probes.size()) return 1'b0;
    foreach (exp_probes[k]) if (obs_probes[k] != exp_probes[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({probe, probe_vld, busy, done, result} !== '0)
      $display("FAIL reset_outputs: got probe=%0d vld=%b busy=%b done=%b result=%0d, want all 0",
               probe, probe_vld, busy, done, result);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || probe_vld !== 1'b0)
      $display("FAIL reset_idle: busy=%b vld=%b want 0 0", busy, probe_vld);
    else passed++;
  endtask

  task automatic test_extremes();
    int tg[3] = '{-32, 31, -1};
    int dc, rs;
    bit st, pl;
    for (int k = 0; k < 3; k++) begin
      build_model(tg[k]);
      do_search(tg[k], 0, 1'b0, dc, rs, st, pl);
      total++;
      if (!probes_match())
        $display("FAIL extreme_probes tgt=%0d: got %0d probes first=%0d, want %0d probes first=%0d",
                 tg[k], obs_probes.size(), (obs_probes.size() > 0) ? obs_probes[0] : 999,
                 exp_probes.size(), exp_probes[0]);
      else passed++;
      total++;
      if (rs != tg[k]) $display("FAIL extreme_result: got %0d want %0d", rs, tg[k]);
      else passed++;
      total++;
      if (dc != W + 1) $display("FAIL extreme_done_cycle tgt=%0d: got %0d want %0d", tg[k], dc, W + 1);
      else passed++;
      total++;
      if (!pl) $display("FAIL extreme_pulse tgt=%0d: got multi-cycle/busy, want single pulse", tg[k]);
      else passed++;
    end
    // Literal sequence for the minimum target.
    build_model(-32);
    do_search(-32, 0, 1'b0, dc, rs, st, pl);
    total++;
    if (obs_probes.size() != 6 || obs_probes[0] != 0 || obs_probes[1] != -16 || obs_probes[2] != -24 ||
        obs_probes[3] != -28 || obs_probes[4] != -30 || obs_probes[5] != -31)
      $display("FAIL min_literal_probes: got size %0d, want 0,-16,-24,-28,-30,-31", obs_probes.size());
    else passed++;
  endtask

  task automatic test_delay();
    int dc, rs;
    bit st, pl;
    build_model(5);
    do_search(5, 3, 1'b1, dc, rs, st, pl);
    total++;
    if (rs != 5) $display("FAIL delay_result: got %0d want 5", rs);
    else passed++;
    total++;
    if (dc != 25) $display("FAIL delay_done_cycle: got %0d want 25", dc);
    else passed++;
    total++;
    if (!st) $display("FAIL delay_probe_stable: got changing probe, want held");
    else passed++;
    total++;
    if (!probes_match()) $display("FAIL delay_probes: got %0d probes want %0d", obs_probes.size(), exp_probes.size());
    else passed++;
  endtask

  task automatic test_random();
    int tgt, dly, dc, rs;
    bit st, pl;
    for (int k = 0; k < 10; k++) begin
      tgt = int'($urandom_range(0, 63)) - 32;
      dly = int'($urandom_range(0, 2));
      build_model(tgt);
      do_search(tgt, dly, 1'b0, dc, rs, st, pl);
      total++;
      if (rs != exp_result || !probes_match() || dc != exp_probes.size() * (dly + 1) + 1 || !st || !pl)
        $display("FAIL random tgt=%0d d=%0d: got result=%0d done_cyc=%0d probes=%0d, want result=%0d done_cyc=%0d probes=%0d",
                 tgt, dly, rs, dc, obs_probes.size(), exp_result,
                 exp_probes.size() * (dly + 1) + 1, exp_probes.size());
      else passed++;
    end
  endtask

  task automatic test_abort_reset();
    int prior, acc_n, dc, rs;
    bit seen_done, st, pl;
    prior = 7;
    do_search(prior, 0, 1'b0, dc, rs, st, pl);
    target_v = 6'd13;
    delay = 0;
    acc_n = 0;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && acc_n < 3; k++) begin
      if (probe_vld && cmp_vld) acc_n++;
      if (acc_n == 3) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    total++;
    if (probe_vld !== 1'b0 || busy !== 1'b0 || acc_n != 3)
      $display("FAIL abort_idle: got vld=%b busy=%b accepted=%0d, want 0 0 3", probe_vld, busy, acc_n);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen_done || int'($signed(result)) != prior)
      $display("FAIL abort_no_done: got done_seen=%b result=%0d, want 0 %0d", seen_done, $signed(result), prior);
    else passed++;
    // Start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || probe_vld !== 1'b0)
      $display("FAIL start_abort_idle: got busy=%b vld=%b want 0 0", busy, probe_vld);
    else passed++;
    // Reset mid-search.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({probe, probe_vld, busy, done, result} !== '0)
      $display("FAIL reset_mid_search: got probe=%0d vld=%b busy=%b done=%b result=%0d, want all 0",
               probe, probe_vld, busy, done, result);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_release: done=%b busy=%b want 0 0", done, busy);
    else passed++;
    build_model(13);
    do_search(13, 0, 1'b0, dc, rs, st, pl);
    total++;
    if (rs != 13 || !probes_match() || !pl)
      $display("FAIL post_reset_search: got result=%0d want 13", rs);
    else passed++;
  endtask

`ifdef SAR_EQ_EXIT_EN
  task automatic test_eq_exit();
    int dc, rs;
    bit st, pl;
    build_model(0);
    do_search(0, 0, 1'b0, dc, rs, st, pl);
    total++;
    if (rs != 0 || dc != 2 || obs_probes.size() != 1)
      $display("FAIL eq_zero: got result=%0d done_cyc=%0d compares=%0d, want 0 2 1", rs, dc, obs_probes.size());
    else passed++;
    build_model(20);
    do_search(20, 0, 1'b0, dc, rs, st, pl);
    total++;
    if (rs != 20 || dc != 5 || obs_probes.size() != 4 || !probes_match())
      $display("FAIL eq_twenty: got result=%0d done_cyc=%0d compares=%0d, want 20 5 4", rs, dc, obs_probes.size());
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_extremes();
    test_delay();
    test_random();
    test_abort_reset();
`ifdef SAR_EQ_EXIT_EN
    test_eq_exit();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
